// File: rtl/uart_reg_decoder.sv
// uart_reg_decoder
// -----------------------------------------------------------------------------
// Byte-level command decoder that sits behind the UART receiver. Received
// bytes are grouped into register write commands (address byte then value
// byte) and register read commands (single byte). Read data goes back to a
// UART transmitter over a valid/ready byte interface. Protocol errors are
// counted in a saturating 8-bit register.
//
// Parameters:
//   CLK_HZ        system clock frequency in Hz
//   BIT_RATE      UART bit rate, used only to size the command timeout
//   TIMEOUT_BYTES byte-times allowed between command byte and value byte
//
// Ports:
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   uart_rx_valid  one-cycle pulse per received byte
//   uart_rx_data   received byte, qualified by uart_rx_valid
//   tx_valid       read-response byte available
//   tx_data        read-response byte, held stable while tx_valid is high
//   tx_ready       transmitter accepts the byte when tx_valid & tx_ready
//   rgb0..rgb3     RGB LED registers (3 bits each)
//   led            green LED register (4 bits)
//   err_count      saturating protocol-error counter
// -----------------------------------------------------------------------------
module uart_reg_decoder #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned BIT_RATE      = 9600,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx_valid,
    input  logic [7:0] uart_rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [2:0] rgb0,
    output logic [2:0] rgb1,
    output logic [2:0] rgb2,
    output logic [2:0] rgb3,
    output logic [3:0] led,
    output logic [7:0] err_count
);

    // Ten bit-times per UART byte (start + 8 data + stop).
    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLK_HZ / BIT_RATE;
    localparam logic [31:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VAL = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  wr_addr;
    logic [7:0]  scratch;
    logic [31:0] timeout_cnt;

    logic [7:0]  read_mux;
    logic        read_mapped;
    logic        write_mapped;
    logic        timeout_hit;
    logic        err_inc;
    logic        err_clr;

    // Read data for the address carried in the incoming byte. Only
    // addresses 0x01-0x07 are mapped; a read of address 0 (byte 0x80) is
    // treated like any other unmapped read.
    always_comb begin
        read_mux    = 8'h00;
        read_mapped = 1'b1;
        case (uart_rx_data[6:0])
            7'h01:   read_mux = {5'b0, rgb0};
            7'h02:   read_mux = {5'b0, rgb1};
            7'h03:   read_mux = {5'b0, rgb2};
            7'h04:   read_mux = {5'b0, rgb3};
            7'h05:   read_mux = {4'b0, led};
            7'h06:   read_mux = scratch;
            7'h07:   read_mux = err_count;
            default: read_mapped = 1'b0;
        endcase
    end

    // Error sources are mutually exclusive by state; the clear still takes
    // priority in the counter update so the ordering is explicit.
    always_comb begin
        write_mapped = (wr_addr >= 7'h01) && (wr_addr <= 7'h07);
        timeout_hit  = (timeout_cnt == TIMEOUT_LAST);
        err_inc      = 1'b0;
        err_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (uart_rx_valid && uart_rx_data[7] && !read_mapped)
                    err_inc = 1'b1;
            end
            WAIT_VAL: begin
                if (uart_rx_valid) begin
                    if (!write_mapped)
                        err_inc = 1'b1;
                    if (wr_addr == 7'h07)
                        err_clr = 1'b1;
                end else if (timeout_hit) begin
                    err_inc = 1'b1;
                end
            end
            RESP: begin
                if (uart_rx_valid)
                    err_inc = 1'b1;
            end
            default: ;
        endcase
    end

    // Main command FSM. All outputs are registered here. In WAIT_VAL an
    // arriving byte takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wr_addr     <= 7'h00;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            rgb0        <= 3'b000;
            rgb1        <= 3'b000;
            rgb2        <= 3'b000;
            rgb3        <= 3'b000;
            led         <= 4'b0000;
            scratch     <= 8'h00;
            err_count   <= 8'h00;
            timeout_cnt <= 32'd0;
        end else begin
            if (err_clr)
                err_count <= 8'h00;
            else if (err_inc && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            case (state)
                IDLE: begin
                    if (uart_rx_valid && (uart_rx_data != 8'h00)) begin
                        if (!uart_rx_data[7]) begin
                            wr_addr     <= uart_rx_data[6:0];
                            timeout_cnt <= 32'd0;
                            state       <= WAIT_VAL;
                        end else begin
                            tx_data  <= read_mux;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                WAIT_VAL: begin
                    if (uart_rx_valid) begin
                        case (wr_addr)
                            7'h01:   rgb0    <= uart_rx_data[2:0];
                            7'h02:   rgb1    <= uart_rx_data[2:0];
                            7'h03:   rgb2    <= uart_rx_data[2:0];
                            7'h04:   rgb3    <= uart_rx_data[2:0];
                            7'h05:   led     <= uart_rx_data[3:0];
                            7'h06:   scratch <= uart_rx_data;
                            default: ;
                        endcase
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
